// File: rtl/ov_cam_axis_bridge_pkg.sv
// Shared types for the OV camera to AXI-Stream bridge: FSM encoding, pixel widths, defaults.
package ov_cam_axis_bridge_pkg;

  localparam int PIX_W        = 8;
  localparam int DATA_W       = 3 * PIX_W;
  localparam int COL_W        = 10;
  localparam int ROW_W        = 9;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2,
    DROP       = 2'd3
  } cam_state_t;

  typedef struct packed {
    logic              tuser;
    logic              tlast;
    logic [DATA_W-1:0] data;
  } pix_entry_t;

  // Capture stage delivers {B,R,G}; the stream carries {R,G,B}.
  function automatic logic [DATA_W-1:0] brg_to_rgb(input logic [DATA_W-1:0] brg);
    return {brg[2*PIX_W-1:PIX_W], brg[PIX_W-1:0], brg[DATA_W-1:2*PIX_W]};
  endfunction

endpackage

// File: rtl/ov_axis_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word; a write into an
// empty FIFO is visible one edge later, and a full FIFO accepts a write alongside a read.
module ov_axis_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     pclk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [AW:0]      count_q;
  logic             do_wr, do_rd;

  always_comb begin
    full       = (count_q == (AW+1)'(DEPTH));
    empty      = (count_q == '0);
    count      = count_q;
    do_rd      = rd_en && !empty;
    do_wr      = wr_en && (!full || do_rd);
    rd_ptr_nxt = rd_ptr + AW'(1);
  end

  always_ff @(posedge pclk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // rd_data always mirrors mem[rd_ptr]; when full, the write lands in the slot being vacated.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr_nxt;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (do_rd) begin
        if (count_q > (AW+1)'(1)) rd_data <= mem[rd_ptr_nxt];
        else if (do_wr)           rd_data <= wr_data;
      end else if (do_wr && empty) begin
        rd_data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ov_cam_axis_bridge.sv
// Frames camera capture pixels into an AXI-Stream video stream (tuser = SOF, tlast = EOL),
// reordering {B,R,G} to {R,G,B}; overflow, short lines and surplus rows raise sticky frame_err.
module ov_cam_axis_bridge
  import ov_cam_axis_bridge_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_hsync,
  input  logic              pix_vsync,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              frame_err
);

  localparam int ENTRY_W = $bits(pix_entry_t);

  cam_state_t                state;
  logic [COL_W-1:0]          col, line_col;
  logic [ROW_W-1:0]          row;
  logic                      sof_pending, vsync_d;
  logic                      fifo_full, fifo_empty, fifo_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      vs_rise, in_active, pix_in, at_eol, frame_over, can_wr;
  logic                      accept, overflow, late_pix, short_line, err_evt;
  pix_entry_t                wr_entry, rd_entry;

  always_comb begin
    fifo_rd    = m_axis_tvalid && m_axis_tready;
    vs_rise    = pix_vsync && !vsync_d;
    in_active  = (state == ACTIVE) && !pix_vsync;
    pix_in     = in_active && pix_valid;
    line_col   = pix_hsync ? '0 : col;
    at_eol     = (line_col == COL_W'(H_ACTIVE - 1));
    frame_over = (row == ROW_W'(V_ACTIVE));
    can_wr     = !fifo_full || fifo_rd;
    accept     = pix_in && !frame_over && can_wr;
    overflow   = pix_in && !frame_over && !can_wr;
    late_pix   = pix_in && frame_over;
    short_line = in_active && pix_hsync && (col != '0);
    err_evt    = overflow || late_pix || short_line;
    wr_entry   = '{tuser: sof_pending, tlast: at_eol, data: brg_to_rgb(pix_data)};
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_VSYNC;
      col         <= '0;
      row         <= '0;
      sof_pending <= 1'b0;
      frame_err   <= 1'b0;
      vsync_d     <= 1'b0;
    end else begin
      vsync_d <= pix_vsync;
      // An error in the same cycle as vsync rising wins over the clear.
      if (err_evt)      frame_err <= 1'b1;
      else if (vs_rise) frame_err <= 1'b0;
      case (state)
        WAIT_VSYNC: if (pix_vsync) state <= WAIT_FRAME;
        WAIT_FRAME: if (!pix_vsync) begin
          state       <= ACTIVE;
          col         <= '0;
          row         <= '0;
          sof_pending <= 1'b1;
        end
        ACTIVE: begin
          if (pix_vsync) begin
            state <= WAIT_FRAME;
          end else begin
            if (overflow) state <= DROP;
            if (accept) begin
              sof_pending <= 1'b0;
              if (at_eol) begin
                col <= '0;
                row <= row + ROW_W'(1);
              end else begin
                col <= line_col + COL_W'(1);
              end
            end else if (pix_hsync) begin
              col <= '0;
            end
          end
        end
        DROP:    if (pix_vsync) state <= WAIT_FRAME;
        default: state <= WAIT_VSYNC;
      endcase
    end
  end

  ov_axis_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk    (pclk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_data (wr_entry),
    .rd_en   (m_axis_tready),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    m_axis_tvalid = !fifo_empty;
    m_axis_tdata  = rd_entry.data;
    m_axis_tuser  = rd_entry.tuser;
    m_axis_tlast  = rd_entry.tlast;
  end

endmodule

// File: tb/tb_ov_cam_axis_bridge.sv
// Directed bench for ov_cam_axis_bridge: framing, reorder, backpressure/overflow, short line,
// row limit, error clear and mid-frame reset.
module tb_ov_cam_axis_bridge;
  import ov_cam_axis_bridge_pkg::*;

  localparam int H = 640;
  localparam int V = 4;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0, pix_hsync = 1'b0, pix_vsync = 1'b0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_err;
  logic        m_axis_tready = 1'b1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [25:0] beats[$];

  always #5 pclk = ~pclk;

  ov_cam_axis_bridge #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(16)) dut (
    .pclk(pclk), .reset(reset), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .frame_err(frame_err)
  );

  // Transfers are captured mid-cycle; inputs only change just after rising edges.
  always @(negedge pclk)
    if (!reset && m_axis_tvalid && m_axis_tready)
      beats.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});

  function automatic logic [23:0] pix(input int n);
    return 24'((n * 32'h0001_0307) ^ 32'h005A_A53C);
  endfunction

  function automatic logic [23:0] rgb(input logic [23:0] d);
    return {d[15:8], d[7:0], d[23:16]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic do_vsync();
    pix_vsync = 1'b1; tick(2);
    pix_vsync = 1'b0; tick(2);
  endtask

  task automatic send_line(input int n, input int base);
    pix_hsync = 1'b1; tick();
    pix_hsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pix_data = pix(base + i); tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    tests_run++; if (m_axis_tdata !== 24'h0) begin tests_failed++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    tests_run++; if ({m_axis_tuser, m_axis_tlast, frame_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {m_axis_tuser, m_axis_tlast, frame_err}); end
    tests_run++; if (dut.state !== WAIT_VSYNC) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.state, WAIT_VSYNC); end
    reset = 1'b0; tick();
  endtask

  task automatic test_reorder_latency();
    do_vsync();
    pix_hsync = 1'b1; tick(); pix_hsync = 1'b0;
    m_axis_tready = 1'b0;
    pix_valid = 1'b1; pix_data = 24'h112233; tick(); pix_valid = 1'b0;
    tests_run++; if (m_axis_tvalid !== 1'b1) begin tests_failed++; $display("FAIL latency_tvalid: got %b want 1", m_axis_tvalid); end
    tests_run++; if (m_axis_tdata !== 24'h223311) begin tests_failed++; $display("FAIL reorder_tdata: got %h want 223311", m_axis_tdata); end
    tests_run++; if ({m_axis_tuser, m_axis_tlast} !== 2'b10) begin tests_failed++; $display("FAIL reorder_user_last: got %b want 10", {m_axis_tuser, m_axis_tlast}); end
    tick(3);
    tests_run++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {2'b11, 24'h223311}) begin tests_failed++; $display("FAIL hold_stable: got %b %b %h want 1 1 223311", m_axis_tvalid, m_axis_tuser, m_axis_tdata); end
    m_axis_tready = 1'b1; tick();
    tests_run++; if (m_axis_tvalid !== 1'b0 || beats.size() != 1) begin tests_failed++; $display("FAIL reorder_drain: tvalid %b beats %0d want 0 1", m_axis_tvalid, beats.size()); end
    beats.delete();
  endtask

  task automatic test_normal_frame();
    int bad;
    m_axis_tready = 1'b1;
    do_vsync();
    send_line(H, 0);
    send_line(H, H);
    tick(5);
    tests_run++; if (beats.size() != 2 * H) begin tests_failed++; $display("FAIL frame_beats: got %0d want %0d", beats.size(), 2 * H); end
    bad = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i][25] !== (i == 0)) bad++;
      if (beats[i][24] !== (i == H - 1 || i == 2 * H - 1)) bad++;
      if (beats[i][23:0] !== rgb(pix(i))) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL frame_content: got %0d bad fields want 0", bad); end
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL frame_err_clean: got %b want 0", frame_err); end
    beats.delete();
  endtask

  task automatic test_backpressure();
    int bad;
    do_vsync();
    m_axis_tready = 1'b1;
    send_line(10, 0);
    tick(3);
    m_axis_tready = 1'b0;
    for (int i = 10; i < 30; i++) begin
      pix_valid = 1'b1; pix_data = pix(i); tick();
    end
    pix_valid = 1'b0;
    tests_run++; if (dut.state !== DROP) begin tests_failed++; $display("FAIL bp_state: got %0d want %0d", dut.state, DROP); end
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL bp_frame_err: got %b want 1", frame_err); end
    tests_run++; if (beats.size() != 10) begin tests_failed++; $display("FAIL bp_pre_beats: got %0d want 10", beats.size()); end
    m_axis_tready = 1'b1;
    tick(25);
    tests_run++; if (beats.size() != 26) begin tests_failed++; $display("FAIL bp_total_beats: got %0d want 26", beats.size()); end
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 0), 1'b0, rgb(pix(i))}) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL bp_order: got %0d bad beats want 0", bad); end
    beats.delete();
  endtask

  task automatic test_short_line();
    int bad;
    do_vsync();
    send_line(100, 0);
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL short_pre_err: got %b want 0", frame_err); end
    send_line(H, 100);
    tick(5);
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL short_err: got %b want 1", frame_err); end
    tests_run++; if (beats.size() != 100 + H) begin tests_failed++; $display("FAIL short_beats: got %0d want %0d", beats.size(), 100 + H); end
    bad = 0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] !== {(i == 0), (i == 100 + H - 1), rgb(pix(i))}) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL short_content: got %0d bad beats want 0", bad); end
    beats.delete();
  endtask

  task automatic test_err_clear();
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL clear_pre: got %b want 1", frame_err); end
    pix_vsync = 1'b1; tick();
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL clear_on_vsync: got %b want 0", frame_err); end
    tests_run++; if (dut.state !== WAIT_FRAME) begin tests_failed++; $display("FAIL clear_state: got %0d want %0d", dut.state, WAIT_FRAME); end
    pix_vsync = 1'b0; tick(2);
  endtask

  task automatic test_row_limit();
    int lasts;
    do_vsync();
    for (int l = 0; l < V; l++) send_line(H, l * H);
    tick();
    tests_run++; if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL rows_pre_err: got %b want 0", frame_err); end
    send_line(3, 9000);
    tick(5);
    tests_run++; if (frame_err !== 1'b1) begin tests_failed++; $display("FAIL rows_late_err: got %b want 1", frame_err); end
    lasts = 0;
    foreach (beats[i]) if (beats[i][24]) lasts++;
    tests_run++; if (beats.size() != V * H || lasts != V) begin tests_failed++; $display("FAIL rows_beats: got %0d beats %0d tlast want %0d %0d", beats.size(), lasts, V * H, V); end
    beats.delete();
  endtask

  task automatic test_mid_reset();
    do_vsync();
    send_line(300, 0);
    tests_run++; if (m_axis_tvalid !== 1'b1) begin tests_failed++; $display("FAIL mreset_pre_valid: got %b want 1", m_axis_tvalid); end
    #2 reset = 1'b1;
    #1;
    tests_run++; if (m_axis_tvalid !== 1'b0) begin tests_failed++; $display("FAIL mreset_tvalid: got %b want 0", m_axis_tvalid); end
    tests_run++; if (dut.state !== WAIT_VSYNC) begin tests_failed++; $display("FAIL mreset_state: got %0d want %0d", dut.state, WAIT_VSYNC); end
    tick(2);
    reset = 1'b0;
    beats.delete();
    send_line(20, 0);
    tick(3);
    tests_run++; if (beats.size() != 0) begin tests_failed++; $display("FAIL mreset_ignored: got %0d beats want 0", beats.size()); end
    pix_vsync = 1'b1;
    send_line(5, 100);
    tick(3);
    tests_run++; if (beats.size() != 0) begin tests_failed++; $display("FAIL mreset_vsync_high: got %0d beats want 0", beats.size()); end
    pix_vsync = 1'b0; tick(2);
    send_line(5, 500);
    tick(4);
    tests_run++; if (beats.size() != 5) begin tests_failed++; $display("FAIL mreset_resume_beats: got %0d want 5", beats.size()); end
    else begin
      tests_run++; if (beats[0] !== {2'b10, rgb(pix(500))} || beats[1][25] !== 1'b0) begin tests_failed++; $display("FAIL mreset_sof: got %h %h want %h", beats[0], beats[1], {2'b10, rgb(pix(500))}); end
    end
    beats.delete();
  endtask

  initial begin
    test_reset();
    test_reorder_latency();
    test_normal_frame();
    test_backpressure();
    test_short_line();
    test_err_clear();
    test_row_limit();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ov_cam_axis_bridge.md
OV_CAM_AXIS_BRIDGE -- requirements
Module: ov_cam_axis_bridge

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16: output FIFO entries, power of two, at least 4.
REQ-004 pclk  in  1  Sole clock; all logic on its rising edge.
REQ-005 reset  in  1  Asynchronous, active-high reset.
REQ-006 pix_data  in  24  Pixel from the capture stage, as {B,R,G}, 8 bits each.
REQ-007 pix_valid  in  1  Pixel qualifier (capture-stage we); one pixel per high cycle.
REQ-008 pix_hsync  in  1  Line-start pulse, one cycle, before the first pixel of a line.
REQ-009 pix_vsync  in  1  Frame blanking level; high between frames.
REQ-010 m_axis_tdata  out  24  Output pixel, reordered to {R,G,B}.
REQ-011 m_axis_tvalid  out  1  Output valid.
REQ-012 m_axis_tready  in  1  Downstream ready.
REQ-013 m_axis_tuser  out  1  Start of frame, set only on the first pixel of a frame.
REQ-014 m_axis_tlast  out  1  End of line, set on pixel H_ACTIVE-1 of each line.
REQ-015 frame_err  out  1  Sticky error flag, cleared on pix_vsync rising.

Function
REQ-016 Pixel accept:
- A pixel is accepted when pix_valid=1, state=ACTIVE and the FIFO is not full.
- Each FIFO entry holds {tuser, tlast, data}.
REQ-017 Transfer: an output beat transfers on tvalid&tready; while tvalid=1 and tready=0, tdata, tuser and tlast are held stable.
REQ-018 Latency: an accepted pixel into an empty FIFO presents tvalid=1 on the next rising edge.
REQ-019 Simultaneous write and read: when the FIFO is full and a read occurs in the same cycle, the write is accepted and the count does not change.
REQ-020 FSM states: WAIT_VSYNC, WAIT_FRAME, ACTIVE, DROP; reset state WAIT_VSYNC.
REQ-021 FSM transitions:
- WAIT_VSYNC -> WAIT_FRAME on pix_vsync=1.
- WAIT_FRAME -> ACTIVE on pix_vsync=0.
- ACTIVE -> DROP when pix_valid=1 and the FIFO is full.
- ACTIVE or DROP -> WAIT_FRAME on pix_vsync=1.
REQ-022 Counters:
- col (10 bits) and row (9 bits) reset to 0 on entry to ACTIVE.
- col resets to 0 on pix_hsync.
- col increments on each accepted pixel; tlast is set when col=H_ACTIVE-1, and col then wraps to 0 and row increments.
- Pixels with col beyond H_ACTIVE-1 cannot occur because of the wrap.
- Pixels arriving once row=V_ACTIVE are discarded and set frame_err.
REQ-023 tuser is set on the first pixel accepted after entry to ACTIVE.
REQ-024 A pix_hsync arriving when col≠0 (short line) sets frame_err; the partial line keeps no tlast.
REQ-025 Overflow: the pixel that hits a full FIFO is dropped and frame_err is set.
- In DROP, all pixels are discarded.
- The FIFO keeps draining while in DROP.
REQ-026 frame_err clears on the pix_vsync rising edge, unless an error condition occurs in the same cycle, in which case it stays set.
REQ-027 pix_valid while pix_vsync=1 is ignored.

Reset
REQ-028 While reset is high:
- FSM=WAIT_VSYNC.
- FIFO empty; m_axis_tvalid, tuser, tlast and frame_err are 0; tdata is 0.
- col and row are 0.
REQ-029 Reset asserted mid-frame discards the FIFO contents; output resumes only after a full vsync high-then-low sequence.

Structure
REQ-030 A shared package holds the FSM state encoding, the pixel field widths and the default H_ACTIVE/V_ACTIVE.
REQ-031 The FIFO is one sub-module, ov_axis_fifo (synchronous, registered output, full/empty/count).

Verification
REQ-032 Normal frame: after reset, vsync 1 then 0, then 2 lines of 640 pixels with tready=1 -> 1280 beats, tuser on beat 0 only, tlast on beats 639 and 1279, frame_err=0.
REQ-033 Data reorder: pix_data=0x11_22_33 -> tdata=0x22_33_11.
REQ-034 Backpressure: tready=0 for 20 cycles mid-line, FIFO_DEPTH=16 -> 16 pixels stored, pixel 17 dropped, frame_err=1, FSM=DROP; the 16 stored beats drain in order once tready=1.
REQ-035 Short line: hsync after 100 pixels -> frame_err=1, no tlast on pixel 99; the next line starts at col=0.
REQ-036 Mid-frame reset: assert reset after 300 pixels -> tvalid=0 at once; pixels are ignored until a vsync high-then-low sequence; the next frame's first beat carries tuser=1.
REQ-037 Error clear: with frame_err=1, a vsync rising edge -> frame_err=0 on the next edge.
